// File: rtl/rename_reg_file.sv
// Architectural register file with per-register ROB rename labels.
// Combinational operand reads with commit bypass; commit/issue/flush updates on clk.
module rename_reg_file #(
    parameter int REG_NUM      = 32,
    parameter int REG_WIDTH    = 5,
    parameter int VAL_WIDTH    = 32,
    parameter int ROB_ID_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush_in,
    input  logic [REG_WIDTH-1:0]  rs1,
    input  logic [REG_WIDTH-1:0]  rs2,
    input  logic                  issue_en,
    input  logic [REG_WIDTH-1:0]  issue_rd,
    input  logic [ROB_ID_WIDTH:0] issue_tag,
    input  logic                  commit_en,
    input  logic [REG_WIDTH-1:0]  commit_rd,
    input  logic [VAL_WIDTH-1:0]  commit_res,
    input  logic [ROB_ID_WIDTH:0] commit_lab,
    output logic [ROB_ID_WIDTH:0] rf_label1,
    output logic [ROB_ID_WIDTH:0] rf_label2,
    output logic [VAL_WIDTH-1:0]  rf_val1,
    output logic [VAL_WIDTH-1:0]  rf_val2
);

    logic [VAL_WIDTH-1:0]  val_q [REG_NUM];
    logic [ROB_ID_WIDTH:0] lab_q [REG_NUM];

    logic commit_wr;
    logic commit_clears;
    logic issue_wr;

    assign commit_wr     = commit_en && (commit_rd != '0);
    assign commit_clears = commit_wr && (lab_q[commit_rd] == commit_lab);
    assign issue_wr      = issue_en && (issue_rd != '0);

    // x0 is only ever touched by reset, so it stays zero without a special case.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                val_q[i] <= '0;
                lab_q[i] <= '0;
            end
        end else if (rdy_in) begin
            if (commit_wr)
                val_q[commit_rd] <= commit_res;
            if (flush_in) begin
                for (int i = 0; i < REG_NUM; i++)
                    lab_q[i] <= '0;
            end else begin
                if (commit_clears)
                    lab_q[commit_rd] <= '0;
                // A same-register issue is the younger producer and overrides the clear.
                if (issue_wr)
                    lab_q[issue_rd] <= issue_tag;
            end
        end
    end

    always_comb begin
        rf_label1 = '0;
        rf_val1   = '0;
        if (rs1 != '0) begin
            if (commit_en && (commit_rd == rs1) && (lab_q[rs1] == commit_lab)) begin
                rf_val1 = commit_res;
            end else begin
                rf_label1 = lab_q[rs1];
                rf_val1   = val_q[rs1];
            end
        end
    end

    always_comb begin
        rf_label2 = '0;
        rf_val2   = '0;
        if (rs2 != '0) begin
            if (commit_en && (commit_rd == rs2) && (lab_q[rs2] == commit_lab)) begin
                rf_val2 = commit_res;
            end else begin
                rf_label2 = lab_q[rs2];
                rf_val2   = val_q[rs2];
            end
        end
    end

endmodule

// File: tb/tb_rename_reg_file.sv
// Directed self-checking bench for rename_reg_file.
// Inputs change 1ns after posedge; combinational reads are checked before the next edge.
module tb_rename_reg_file;

    logic        clk;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_in;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic [3:0]  issue_tag;
    logic        commit_en;
    logic [4:0]  commit_rd;
    logic [31:0] commit_res;
    logic [3:0]  commit_lab;
    logic [3:0]  rf_label1;
    logic [3:0]  rf_label2;
    logic [31:0] rf_val1;
    logic [31:0] rf_val2;

    int n_checks = 0;
    int n_errors = 0;

    rename_reg_file dut (
        .clk        (clk),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .flush_in   (flush_in),
        .rs1        (rs1),
        .rs2        (rs2),
        .issue_en   (issue_en),
        .issue_rd   (issue_rd),
        .issue_tag  (issue_tag),
        .commit_en  (commit_en),
        .commit_rd  (commit_rd),
        .commit_res (commit_res),
        .commit_lab (commit_lab),
        .rf_label1  (rf_label1),
        .rf_label2  (rf_label2),
        .rf_val1    (rf_val1),
        .rf_val2    (rf_val2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        issue_en  = 1'b0;
        commit_en = 1'b0;
        flush_in  = 1'b0;
        rdy_in    = 1'b1;
    endtask

    initial begin
        rst_in = 1'b0;
        rdy_in = 1'b1;
        flush_in = 1'b0;
        rs1 = 5'd5;
        rs2 = 5'd31;
        issue_en = 1'b0;
        issue_rd = '0;
        issue_tag = '0;
        commit_en = 1'b0;
        commit_rd = '0;
        commit_res = '0;
        commit_lab = '0;

        // reset state
        #2;
        check_eq("rst_label1", 32'(rf_label1), 32'd0);
        check_eq("rst_label2", 32'(rf_label2), 32'd0);
        check_eq("rst_val1", rf_val1, 32'd0);
        check_eq("rst_val2", rf_val2, 32'd0);
        #1 rst_in = 1'b1;
        step();

        // rename then commit with bypass
        issue_en = 1'b1; issue_rd = 5'd3; issue_tag = 4'd2;
        step();
        issue_en = 1'b0; rs1 = 5'd3;
        #1;
        check_eq("ren_label", 32'(rf_label1), 32'd2);
        commit_en = 1'b1; commit_rd = 5'd3; commit_lab = 4'd2; commit_res = 32'h55;
        #1;
        check_eq("byp_label", 32'(rf_label1), 32'd0);
        check_eq("byp_val", rf_val1, 32'h55);
        step();
        commit_en = 1'b0;
        #1;
        check_eq("cmt_label", 32'(rf_label1), 32'd0);
        check_eq("cmt_val", rf_val1, 32'h55);

        // stale commit must not clear a younger rename
        issue_en = 1'b1; issue_rd = 5'd4; issue_tag = 4'd1;
        step();
        issue_tag = 4'd5;
        step();
        issue_en = 1'b0;
        commit_en = 1'b1; commit_rd = 5'd4; commit_lab = 4'd1; commit_res = 32'd7;
        rs1 = 5'd4;
        #1;
        check_eq("stale_nobyp_label", 32'(rf_label1), 32'd5);
        check_eq("stale_nobyp_val", rf_val1, 32'd0);
        step();
        commit_en = 1'b0;
        #1;
        check_eq("stale_label", 32'(rf_label1), 32'd5);
        check_eq("stale_val", rf_val1, 32'd7);

        // same-cycle issue and commit on one register
        issue_en = 1'b1; issue_rd = 5'd6; issue_tag = 4'd3;
        step();
        issue_tag = 4'd4;
        commit_en = 1'b1; commit_rd = 5'd6; commit_lab = 4'd3; commit_res = 32'd9;
        rs2 = 5'd6;
        #1;
        check_eq("ic_byp_label", 32'(rf_label2), 32'd0);
        check_eq("ic_byp_val", rf_val2, 32'd9);
        step();
        clear_ctl();
        #1;
        check_eq("ic_label", 32'(rf_label2), 32'd4);
        check_eq("ic_val", rf_val2, 32'd9);

        // rename x1..x31, tags cycle 1..8 (exercises the top tag 8)
        issue_en = 1'b1;
        for (int i = 1; i < 32; i++) begin
            issue_rd  = 5'(i);
            issue_tag = 4'((i % 8) + 1);
            step();
        end
        issue_en = 1'b0;
        rs1 = 5'd1; rs2 = 5'd31;
        #1;
        check_eq("ren_x1", 32'(rf_label1), 32'd2);
        check_eq("ren_x31", 32'(rf_label2), 32'd8);

        // flush with a non-matching commit to x2 and a dropped issue to x7
        flush_in = 1'b1;
        commit_en = 1'b1; commit_rd = 5'd2; commit_lab = 4'd1; commit_res = 32'hAA;
        issue_en = 1'b1; issue_rd = 5'd7; issue_tag = 4'd8;
        step();
        clear_ctl();
        for (int i = 1; i < 32; i++) begin
            rs1 = 5'(i);
            #1;
            check_eq($sformatf("flush_label_x%0d", i), 32'(rf_label1), 32'd0);
        end
        rs1 = 5'd2; rs2 = 5'd3;
        #1;
        check_eq("flush_val_x2", rf_val1, 32'hAA);
        check_eq("flush_val_x3", rf_val2, 32'h55);

        // x0 writes and renames are ignored
        issue_en = 1'b1; issue_rd = 5'd0; issue_tag = 4'd3;
        commit_en = 1'b1; commit_rd = 5'd0; commit_lab = 4'd0; commit_res = 32'd1;
        step();
        clear_ctl();
        rs1 = 5'd0;
        #1;
        check_eq("x0_label", 32'(rf_label1), 32'd0);
        check_eq("x0_val", rf_val1, 32'd0);

        // rdy_in low blocks issue, flush and commit
        issue_en = 1'b1; issue_rd = 5'd9; issue_tag = 4'd2;
        step();
        clear_ctl();
        rdy_in = 1'b0;
        issue_en = 1'b1; issue_rd = 5'd9; issue_tag = 4'd6;
        step();
        issue_en = 1'b0;
        rs1 = 5'd9;
        #1;
        check_eq("rdy_issue_label", 32'(rf_label1), 32'd2);
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        #1;
        check_eq("rdy_flush_label", 32'(rf_label1), 32'd2);
        commit_en = 1'b1; commit_rd = 5'd9; commit_lab = 4'd2; commit_res = 32'h33;
        #1;
        check_eq("rdy_byp_label", 32'(rf_label1), 32'd0);
        check_eq("rdy_byp_val", rf_val1, 32'h33);
        step();
        clear_ctl();
        #1;
        check_eq("rdy_cmt_label", 32'(rf_label1), 32'd2);
        check_eq("rdy_cmt_val", rf_val1, 32'd0);

        // asynchronous reset between clock edges
        rs2 = 5'd3;
        #1 rst_in = 1'b0;
        #1;
        check_eq("arst_label", 32'(rf_label1), 32'd0);
        check_eq("arst_val", rf_val2, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
